// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-RAM arbiter: read-return owner and starvation FSM state.
// No timing of its own; the helper below is pure combinational decode.
package dmem_arbiter_pkg;

    localparam int BSEL_BUS = 4;
    localparam int CNT_W    = 8;

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_CPU_RD = 2'd1,
        OWN_AUX_RD = 2'd2
    } owner_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    // Who will own next cycle's ram_douta; writes return nothing worth tracking.
    function automatic owner_t read_owner(
        input logic                cpu_sel,
        input logic [BSEL_BUS-1:0] cpu_we,
        input logic                aux_gnt,
        input logic [BSEL_BUS-1:0] aux_we
    );
        owner_t own;
        own = OWN_NONE;
        if (cpu_sel) begin
            if (cpu_we == '0) own = OWN_CPU_RD;
        end else if (aux_gnt) begin
            if (aux_we == '0) own = OWN_AUX_RD;
        end
        return own;
    endfunction

endpackage

// File: rtl/dmem_starve_ctr.sv
// Bounds aux starvation: after MAX_WAIT-1 refused cycles, cpu_stall registers high for one cycle.
// One-cycle registered output; aux_gnt is the only back-pressure it observes.
module dmem_starve_ctr
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic aux_req,
    input  logic aux_gnt,
    output logic cpu_stall
);

    localparam logic [CNT_W-1:0] LAST_REFUSAL = CNT_W'(MAX_WAIT - 1);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             refused;
    logic [CNT_W-1:0] cnt_inc;

    assign refused = aux_req & ~aux_gnt;
    assign cnt_inc = wait_cnt + CNT_W'(1);

    // wait_cnt holds refusals so far; the stall is armed when this cycle's refusal
    // reaches MAX_WAIT-1, so the forced grant lands on the MAX_WAIT-th waiting cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            cpu_stall <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cpu_stall <= 1'b0;
                    if (refused) begin
                        if (LAST_REFUSAL == CNT_W'(1)) begin
                            state     <= ST_STALL;
                            wait_cnt  <= LAST_REFUSAL;
                            cpu_stall <= 1'b1;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= CNT_W'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (!refused) begin
                        state    <= ST_IDLE;
                        wait_cnt <= '0;
                    end else if (cnt_inc == LAST_REFUSAL) begin
                        state     <= ST_STALL;
                        wait_cnt  <= LAST_REFUSAL;
                        cpu_stall <= 1'b1;
                    end else begin
                        wait_cnt <= cnt_inc;
                    end
                end
                ST_STALL: begin
                    state     <= ST_IDLE;
                    wait_cnt  <= '0;
                    cpu_stall <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    wait_cnt  <= '0;
                    cpu_stall <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between CPU (fixed priority) and one aux master; zero-latency mux.
// Aux is back-pressured by withholding aux_gnt; read data returns one cycle after issue.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic                cpu_clk_50M,
    input  logic                cpu_rst_n,
    input  logic                cpu_dce,
    input  logic [31:0]         cpu_daddr,
    input  logic [BSEL_BUS-1:0] cpu_we,
    input  logic [DATA_W-1:0]   cpu_din,
    output logic [DATA_W-1:0]   cpu_dm,
    output logic                cpu_stall,
    input  logic                aux_req,
    input  logic [31:0]         aux_addr,
    input  logic [BSEL_BUS-1:0] aux_we,
    input  logic [DATA_W-1:0]   aux_wdata,
    output logic                aux_gnt,
    output logic                aux_rvalid,
    output logic [DATA_W-1:0]   aux_rdata,
    output logic                ram_ena,
    output logic [BSEL_BUS-1:0] ram_wea,
    output logic [ADDR_W-1:0]   ram_addra,
    output logic [DATA_W-1:0]   ram_dina,
    input  logic [DATA_W-1:0]   ram_douta
);

    logic   cpu_sel;
    owner_t owner_q;
    owner_t owner_nxt;
    logic   unused_addr_bits;

    // Reset gating keeps the RAM quiet even though cpu_dce/aux_req may be live in reset.
    assign cpu_sel = cpu_rst_n & cpu_dce & ~cpu_stall;
    assign aux_gnt = cpu_rst_n & aux_req & ~cpu_sel;

    always_comb begin
        ram_ena   = 1'b0;
        ram_wea   = '0;
        ram_addra = '0;
        ram_dina  = '0;
        if (cpu_sel) begin
            ram_ena   = 1'b1;
            ram_wea   = cpu_we;
            ram_addra = cpu_daddr[ADDR_W+1:2];
            ram_dina  = cpu_din;
        end else if (aux_gnt) begin
            ram_ena   = 1'b1;
            ram_wea   = aux_we;
            ram_addra = aux_addr[ADDR_W+1:2];
            ram_dina  = aux_wdata;
        end
    end

    assign owner_nxt = read_owner(cpu_sel, cpu_we, aux_gnt, aux_we);

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_nxt;
        end
    end

    assign aux_rvalid = (owner_q == OWN_AUX_RD);
    assign aux_rdata  = aux_rvalid ? ram_douta : '0;
    assign cpu_dm     = ram_douta;

    dmem_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk       (cpu_clk_50M),
        .rst_n     (cpu_rst_n),
        .aux_req   (aux_req),
        .aux_gnt   (aux_gnt),
        .cpu_stall (cpu_stall)
    );

    assign unused_addr_bits = ^{cpu_daddr[31:ADDR_W+2], cpu_daddr[1:0],
                                aux_addr[31:ADDR_W+2], aux_addr[1:0]};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural byte-enabled synchronous RAM.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic        clk;
    logic        cpu_rst_n;
    logic        cpu_dce;
    logic [31:0] cpu_daddr;
    logic [3:0]  cpu_we;
    logic [31:0] cpu_din;
    logic [31:0] cpu_dm;
    logic        cpu_stall;
    logic        aux_req;
    logic [31:0] aux_addr;
    logic [3:0]  aux_we;
    logic [31:0] aux_wdata;
    logic        aux_gnt;
    logic        aux_rvalid;
    logic [31:0] aux_rdata;
    logic        ram_ena;
    logic [3:0]  ram_wea;
    logic [10:0] ram_addra;
    logic [31:0] ram_dina;
    logic [31:0] ram_douta;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:2047];

    dmem_arbiter #(.ADDR_W(11), .DATA_W(32), .MAX_WAIT(8)) u_dut (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (cpu_rst_n),
        .cpu_dce     (cpu_dce),
        .cpu_daddr   (cpu_daddr),
        .cpu_we      (cpu_we),
        .cpu_din     (cpu_din),
        .cpu_dm      (cpu_dm),
        .cpu_stall   (cpu_stall),
        .aux_req     (aux_req),
        .aux_addr    (aux_addr),
        .aux_we      (aux_we),
        .aux_wdata   (aux_wdata),
        .aux_gnt     (aux_gnt),
        .aux_rvalid  (aux_rvalid),
        .aux_rdata   (aux_rdata),
        .ram_ena     (ram_ena),
        .ram_wea     (ram_wea),
        .ram_addra   (ram_addra),
        .ram_dina    (ram_dina),
        .ram_douta   (ram_douta)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (ram_ena) begin
            ram_douta <= mem[ram_addra];
            for (int b = 0; b < 4; b++)
                if (ram_wea[b]) mem[ram_addra][8*b +: 8] <= ram_dina[8*b +: 8];
        end
    end

    task automatic idle_inputs;
        cpu_dce = 1'b0; cpu_daddr = '0; cpu_we = '0; cpu_din = '0;
        aux_req = 1'b0; aux_addr = '0; aux_we = '0; aux_wdata = '0;
    endtask

    task automatic test_reset;
        cpu_rst_n = 1'b0;
        cpu_dce = 1'b1; cpu_daddr = 32'h100;
        aux_req = 1'b1; aux_addr = 32'h200;
        @(negedge clk); #1;
        checks++; if (ram_ena !== 1'b0) begin errors++; $display("FAIL reset_ram_ena got %b exp 0", ram_ena); end
        checks++; if (aux_gnt !== 1'b0) begin errors++; $display("FAIL reset_aux_gnt got %b exp 0", aux_gnt); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_cpu_stall got %b exp 0", cpu_stall); end
        checks++; if (aux_rvalid !== 1'b0) begin errors++; $display("FAIL reset_aux_rvalid got %b exp 0", aux_rvalid); end
        checks++; if (u_dut.u_starve.state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d exp 0", u_dut.u_starve.state); end
        idle_inputs();
        @(negedge clk);
        cpu_rst_n = 1'b1;
    endtask

    task automatic test_cpu_only;
        @(negedge clk);
        cpu_dce = 1'b1; cpu_daddr = 32'h100; cpu_we = 4'hF; cpu_din = 32'hDEADBEEF;
        #1;
        checks++; if ({ram_ena, ram_wea, ram_addra, ram_dina} !== {1'b1, 4'hF, 11'h040, 32'hDEADBEEF}) begin
            errors++; $display("FAIL cpu_wr_pins got %b %h %h %h exp 1 f 040 deadbeef", ram_ena, ram_wea, ram_addra, ram_dina); end
        checks++; if (aux_gnt !== 1'b0) begin errors++; $display("FAIL cpu_wr_aux_gnt got %b exp 0", aux_gnt); end
        @(negedge clk);
        cpu_daddr = 32'h2104; cpu_we = 4'h3; cpu_din = 32'hAABBCCDD;
        #1;
        checks++; if ({ram_wea, ram_addra} !== {4'h3, 11'h041}) begin
            errors++; $display("FAIL cpu_wr_wrap got %h %h exp 3 041", ram_wea, ram_addra); end
        @(negedge clk);
        cpu_daddr = 32'h100; cpu_we = 4'h0; cpu_din = 32'h0;
        #1;
        checks++; if ({ram_ena, ram_wea, ram_addra} !== {1'b1, 4'h0, 11'h040}) begin
            errors++; $display("FAIL cpu_rd_pins got %b %h %h exp 1 0 040", ram_ena, ram_wea, ram_addra); end
        @(negedge clk);
        cpu_daddr = 32'h104;
        #1;
        checks++; if (cpu_dm !== 32'hDEADBEEF) begin errors++; $display("FAIL cpu_rd_data got %h exp deadbeef", cpu_dm); end
        checks++; if (aux_rvalid !== 1'b0) begin errors++; $display("FAIL cpu_rd_no_aux_rvalid got %b exp 0", aux_rvalid); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (cpu_dm !== 32'h0000CCDD) begin errors++; $display("FAIL cpu_byte_en got %h exp 0000ccdd", cpu_dm); end
        checks++; if ({ram_ena, cpu_stall} !== 2'b00) begin errors++; $display("FAIL cpu_idle got %b%b exp 00", ram_ena, cpu_stall); end
    endtask

    task automatic test_aux_read;
        @(negedge clk);
        aux_req = 1'b1; aux_addr = 32'h100; aux_we = 4'h0;
        #1;
        checks++; if ({aux_gnt, ram_ena, ram_wea, ram_addra} !== {1'b1, 1'b1, 4'h0, 11'h040}) begin
            errors++; $display("FAIL aux_rd_issue got %b %b %h %h exp 1 1 0 040", aux_gnt, ram_ena, ram_wea, ram_addra); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (aux_rvalid !== 1'b1) begin errors++; $display("FAIL aux_rvalid got %b exp 1", aux_rvalid); end
        checks++; if (aux_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL aux_rdata got %h exp deadbeef", aux_rdata); end
        @(negedge clk); #1;
        checks++; if ({aux_rvalid, aux_rdata} !== {1'b0, 32'h0}) begin
            errors++; $display("FAIL aux_rdata_gate got %b %h exp 0 0", aux_rvalid, aux_rdata); end
    endtask

    task automatic test_contention;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cpu_dce = 1'b1; cpu_daddr = 32'h0; cpu_we = 4'h0;
            aux_req = 1'b1; aux_addr = 32'h200; aux_we = 4'hF; aux_wdata = 32'h12345678;
            #1;
            if (i < 7) begin
                checks++; if ({aux_gnt, cpu_stall, ram_addra} !== {1'b0, 1'b0, 11'h000}) begin
                    errors++; $display("FAIL contend_refused[%0d] got gnt=%b stall=%b addr=%h exp 0 0 000", i, aux_gnt, cpu_stall, ram_addra); end
            end else begin
                checks++; if ({cpu_stall, aux_gnt} !== 2'b11) begin
                    errors++; $display("FAIL contend_stall got stall=%b gnt=%b exp 1 1", cpu_stall, aux_gnt); end
                checks++; if ({ram_wea, ram_addra, ram_dina} !== {4'hF, 11'h080, 32'h12345678}) begin
                    errors++; $display("FAIL contend_aux_wr got %h %h %h exp f 080 12345678", ram_wea, ram_addra, ram_dina); end
            end
        end
        @(negedge clk);
        aux_req = 1'b0; aux_we = 4'h0; aux_wdata = '0;
        cpu_daddr = 32'h200;
        #1;
        checks++; if ({cpu_stall, aux_gnt, ram_ena, ram_addra} !== {1'b0, 1'b0, 1'b1, 11'h080}) begin
            errors++; $display("FAIL contend_resume got %b %b %b %h exp 0 0 1 080", cpu_stall, aux_gnt, ram_ena, ram_addra); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (cpu_dm !== 32'h12345678) begin errors++; $display("FAIL contend_readback got %h exp 12345678", cpu_dm); end
    endtask

    task automatic test_back_to_back;
        int gnt_cnt;
        int dbl;
        logic prev_stall;
        gnt_cnt = 0; dbl = 0; prev_stall = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cpu_dce = 1'b1; cpu_daddr = 32'h0; cpu_we = 4'h0;
            aux_req = 1'b1; aux_addr = 32'h0; aux_we = 4'h0;
            #1;
            checks++; if (cpu_stall !== ((i % 8) == 7)) begin
                errors++; $display("FAIL b2b_stall[%0d] got %b exp %b", i, cpu_stall, ((i % 8) == 7)); end
            if (aux_gnt === 1'b1) gnt_cnt++;
            if (prev_stall && cpu_stall) dbl++;
            prev_stall = cpu_stall;
        end
        checks++; if (gnt_cnt != 12) begin errors++; $display("FAIL b2b_gnt_count got %0d exp 12", gnt_cnt); end
        checks++; if (dbl != 0) begin errors++; $display("FAIL b2b_double_stall got %0d exp 0", dbl); end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_drop;
        int stalls;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cpu_dce = 1'b1; aux_req = (i < 4); aux_addr = 32'h300;
            #1;
            if (i == 4) begin
                checks++; if (u_dut.u_starve.wait_cnt !== 8'd4) begin
                    errors++; $display("FAIL drop_cnt_at_drop got %0d exp 4", u_dut.u_starve.wait_cnt); end
            end
        end
        @(negedge clk); #1;
        checks++; if ({u_dut.u_starve.state, u_dut.u_starve.wait_cnt} !== {ST_IDLE, 8'd0}) begin
            errors++; $display("FAIL drop_idle got st=%0d cnt=%0d exp 0 0", u_dut.u_starve.state, u_dut.u_starve.wait_cnt); end
        stalls = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (cpu_stall === 1'b1) stalls++;
        end
        checks++; if (stalls != 0) begin errors++; $display("FAIL drop_no_stall got %0d exp 0", stalls); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            aux_req = 1'b1;
            #1;
            if (i == 1) begin
                checks++; if (u_dut.u_starve.wait_cnt !== 8'd1) begin
                    errors++; $display("FAIL drop_restart_cnt got %0d exp 1", u_dut.u_starve.wait_cnt); end
            end
            checks++; if ({cpu_stall, aux_gnt} !== {(i == 7), (i == 7)}) begin
                errors++; $display("FAIL drop_restart[%0d] got %b%b exp %b%b", i, cpu_stall, aux_gnt, (i == 7), (i == 7)); end
        end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_reset_in_stall;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cpu_dce = 1'b1; aux_req = 1'b1; aux_addr = 32'h100; aux_we = 4'h0;
            #1;
        end
        checks++; if ({cpu_stall, aux_gnt} !== 2'b11) begin
            errors++; $display("FAIL rst_stall_pre got %b%b exp 11", cpu_stall, aux_gnt); end
        #1 cpu_rst_n = 1'b0;
        #1;
        checks++; if ({cpu_stall, aux_gnt, ram_ena} !== 3'b000) begin
            errors++; $display("FAIL rst_stall_now got %b%b%b exp 000", cpu_stall, aux_gnt, ram_ena); end
        @(negedge clk); #1;
        checks++; if ({aux_rvalid, u_dut.u_starve.state} !== {1'b0, ST_IDLE}) begin
            errors++; $display("FAIL rst_stall_after got rv=%b st=%0d exp 0 0", aux_rvalid, u_dut.u_starve.state); end
        idle_inputs();
        cpu_rst_n = 1'b1;
        @(negedge clk); #1;
        checks++; if ({aux_rvalid, cpu_stall} !== 2'b00) begin
            errors++; $display("FAIL rst_stall_release got %b%b exp 00", aux_rvalid, cpu_stall); end
        // Pending aux read killed by reset after issue
        @(negedge clk);
        aux_req = 1'b1; aux_addr = 32'h100;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (aux_rvalid !== 1'b1) begin errors++; $display("FAIL rst_pend_pre got %b exp 1", aux_rvalid); end
        cpu_rst_n = 1'b0;
        #1;
        checks++; if ({aux_rvalid, aux_rdata} !== {1'b0, 32'h0}) begin
            errors++; $display("FAIL rst_pend_kill got %b %h exp 0 0", aux_rvalid, aux_rdata); end
        @(negedge clk);
        cpu_rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        for (int a = 0; a < 2048; a++) mem[a] = '0;
        ram_douta = '0;
        idle_inputs();
        cpu_rst_n = 1'b0;
        test_reset();
        test_cpu_only();
        test_aux_read();
        test_contention();
        test_back_to_back();
        test_drop();
        test_reset_in_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
